// File: rtl/sfft_peak_finder.sv
// Per-band peak search over one SFFT output spectrum read from BRAM, with a
// double-buffered committed result bank for software readout.
module sfft_peak_finder #(
  parameter int BIN_ADDR_WIDTH = 8,
  parameter int BAND_SEL_WIDTH = 3,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_valid,
  input  logic [31:0]               time_stamp,
  input  logic [DATA_WIDTH-1:0]     threshold,
  output logic [BIN_ADDR_WIDTH-1:0] bin_addr,
  input  logic [DATA_WIDTH-1:0]     bin_data,
  output logic                      scan_busy,
  output logic                      frame_done,
  input  logic [BAND_SEL_WIDTH-1:0] rd_band,
  output logic [BIN_ADDR_WIDTH-1:0] rd_bin,
  output logic [DATA_WIDTH-1:0]     rd_mag,
  output logic                      rd_hit,
  output logic [31:0]               rd_time,
  output logic [7:0]                dropped_frames
);

  localparam int NUM_BANDS = 2 ** BAND_SEL_WIDTH;
  localparam int OFS_W     = BIN_ADDR_WIDTH - BAND_SEL_WIDTH;
  localparam logic [BIN_ADDR_WIDTH-1:0] LAST_ADDR = {BIN_ADDR_WIDTH{1'b1}};
  localparam logic [BIN_ADDR_WIDTH-1:0] ADDR_ONE  = {{(BIN_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OFS_W-1:0]          OFS_FIRST = {OFS_W{1'b0}};
  localparam logic [OFS_W-1:0]          OFS_LAST  = {OFS_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t                      state_r, state_s;
  logic                        fv_prev_r;
  logic                        rise_s;
  logic [BIN_ADDR_WIDTH-1:0]   bin_addr_r;
  logic [BIN_ADDR_WIDTH-1:0]   addr_d_r;
  logic                        data_vld_r;
  logic [31:0]                 ts_r;
  logic [DATA_WIDTH-1:0]       thr_r;
  logic [DATA_WIDTH-1:0]       max_mag_r, cand_mag_s;
  logic [BIN_ADDR_WIDTH-1:0]   max_bin_r, cand_bin_s;
  logic [BAND_SEL_WIDTH-1:0]   band_s;
  logic [OFS_W-1:0]            ofs_s;
  logic                        scan_busy_r;
  logic                        frame_done_r;
  logic [7:0]                  dropped_r;
  logic [31:0]                 com_time_r;

  logic [BIN_ADDR_WIDTH-1:0]   work_bin_r [NUM_BANDS];
  logic [DATA_WIDTH-1:0]       work_mag_r [NUM_BANDS];
  logic                        work_hit_r [NUM_BANDS];
  logic [BIN_ADDR_WIDTH-1:0]   com_bin_r  [NUM_BANDS];
  logic [DATA_WIDTH-1:0]       com_mag_r  [NUM_BANDS];
  logic                        com_hit_r  [NUM_BANDS];

  assign rise_s = frame_valid & ~fv_prev_r;
  assign band_s = addr_d_r[BIN_ADDR_WIDTH-1 -: BAND_SEL_WIDTH];
  assign ofs_s  = addr_d_r[OFS_W-1:0];

  // Next-state decode of the scan sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) state_s = ST_SCAN;
        else        state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (bin_addr_r == LAST_ADDR) state_s = ST_FLUSH;
        else                         state_s = ST_SCAN;
      end
      ST_FLUSH:  state_s = ST_COMMIT;
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Running-max candidate; strict compare keeps the lowest index on ties
  always_comb begin
    cand_mag_s = max_mag_r;
    cand_bin_s = max_bin_r;
    if (ofs_s == OFS_FIRST) begin
      cand_mag_s = bin_data;
      cand_bin_s = addr_d_r;
    end else if (bin_data > max_mag_r) begin
      cand_mag_s = bin_data;
      cand_bin_s = addr_d_r;
    end else begin
      cand_mag_s = max_mag_r;
      cand_bin_s = max_bin_r;
    end
  end

  // Sequencer state, address generation, frame latches and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      fv_prev_r    <= 1'b1;
      bin_addr_r   <= {BIN_ADDR_WIDTH{1'b0}};
      addr_d_r     <= {BIN_ADDR_WIDTH{1'b0}};
      data_vld_r   <= 1'b0;
      ts_r         <= 32'd0;
      thr_r        <= {DATA_WIDTH{1'b0}};
      scan_busy_r  <= 1'b0;
      frame_done_r <= 1'b0;
      dropped_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      fv_prev_r    <= frame_valid;
      addr_d_r     <= bin_addr_r;
      data_vld_r   <= (state_r == ST_SCAN);
      scan_busy_r  <= (state_s != ST_IDLE);
      frame_done_r <= (state_r == ST_COMMIT);
      if (state_r == ST_IDLE && rise_s) begin
        bin_addr_r <= {BIN_ADDR_WIDTH{1'b0}};
        ts_r       <= time_stamp;
        thr_r      <= threshold;
      end else if (state_r == ST_SCAN && bin_addr_r != LAST_ADDR) begin
        bin_addr_r <= bin_addr_r + ADDR_ONE;
      end
      // Edges that arrive while a frame is in flight are counted, not queued
      if (state_r != ST_IDLE && rise_s && dropped_r != 8'hFF) begin
        dropped_r <= dropped_r + 8'd1;
      end
    end
  end

  // Working per-band results, filled as each band's last bin drains
  always_ff @(posedge clk) begin
    if (reset) begin
      max_mag_r <= {DATA_WIDTH{1'b0}};
      max_bin_r <= {BIN_ADDR_WIDTH{1'b0}};
      for (int i = 0; i < NUM_BANDS; i++) begin
        work_bin_r[i] <= {BIN_ADDR_WIDTH{1'b0}};
        work_mag_r[i] <= {DATA_WIDTH{1'b0}};
        work_hit_r[i] <= 1'b0;
      end
    end else if (data_vld_r) begin
      max_mag_r <= cand_mag_s;
      max_bin_r <= cand_bin_s;
      if (ofs_s == OFS_LAST) begin
        work_bin_r[band_s] <= cand_bin_s;
        work_mag_r[band_s] <= cand_mag_s;
        work_hit_r[band_s] <= (cand_mag_s > thr_r);
      end
    end
  end

  // Committed bank: updated atomically so readout never sees a partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      com_time_r <= 32'd0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        com_bin_r[i] <= {BIN_ADDR_WIDTH{1'b0}};
        com_mag_r[i] <= {DATA_WIDTH{1'b0}};
        com_hit_r[i] <= 1'b0;
      end
    end else if (state_r == ST_COMMIT) begin
      com_time_r <= ts_r;
      for (int i = 0; i < NUM_BANDS; i++) begin
        com_bin_r[i] <= work_bin_r[i];
        com_mag_r[i] <= work_mag_r[i];
        com_hit_r[i] <= work_hit_r[i];
      end
    end
  end

  assign bin_addr       = bin_addr_r;
  assign scan_busy      = scan_busy_r;
  assign frame_done     = frame_done_r;
  assign dropped_frames = dropped_r;
  assign rd_time        = com_time_r;
  assign rd_bin         = com_bin_r[rd_band];
  assign rd_mag         = com_mag_r[rd_band];
  assign rd_hit         = com_hit_r[rd_band];

endmodule

// File: tb/tb_sfft_peak_finder.sv
// Randomized and directed bench for sfft_peak_finder against a per-band
// peak model computed from a BRAM image held in the bench.
module tb_sfft_peak_finder;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_valid;
  logic [31:0] time_stamp;
  logic [31:0] threshold;
  logic [7:0]  bin_addr;
  logic [31:0] bin_data;
  logic        scan_busy;
  logic        frame_done;
  logic [2:0]  rd_band;
  logic [7:0]  rd_bin;
  logic [31:0] rd_mag;
  logic        rd_hit;
  logic [31:0] rd_time;
  logic [7:0]  dropped_frames;

  logic [31:0] mem [256];
  int          exp_bin [8];
  logic [31:0] exp_mag [8];
  logic        exp_hit [8];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_drop = 0;
  int          first_busy, last_busy;

  always #10 clk = ~clk;

  // BRAM model: one-cycle read latency
  always @(posedge clk) bin_data <= mem[bin_addr];

  sfft_peak_finder dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .time_stamp(time_stamp),
    .threshold(threshold), .bin_addr(bin_addr), .bin_data(bin_data),
    .scan_busy(scan_busy), .frame_done(frame_done), .rd_band(rd_band),
    .rd_bin(rd_bin), .rd_mag(rd_mag), .rd_hit(rd_hit), .rd_time(rd_time),
    .dropped_frames(dropped_frames)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: each band of 32 bins reports its largest value, first occurrence wins
  task automatic build_model(input logic [31:0] thr);
    for (int b = 0; b < 8; b++) begin
      exp_bin[b] = b * 32;
      exp_mag[b] = mem[b * 32];
      for (int j = 1; j < 32; j++) begin
        if (mem[b * 32 + j] > exp_mag[b]) begin
          exp_mag[b] = mem[b * 32 + j];
          exp_bin[b] = b * 32 + j;
        end
      end
      exp_hit[b] = (exp_mag[b] > thr);
    end
  endtask

  task automatic check_results(input string p, input logic [31:0] etime);
    chk({p, "_time"}, rd_time, etime);
    for (int b = 0; b < 8; b++) begin
      rd_band = b[2:0];
      #1;
      chk($sformatf("%s_bin%0d", p, b), rd_bin, exp_bin[b]);
      chk($sformatf("%s_mag%0d", p, b), rd_mag, exp_mag[b]);
      chk($sformatf("%s_hit%0d", p, b), rd_hit, exp_hit[b]);
    end
  endtask

  task automatic check_zero(input string p);
    chk({p, "_time"}, rd_time, 32'd0);
    for (int b = 0; b < 8; b++) begin
      rd_band = b[2:0];
      #1;
      chk($sformatf("%s_zero%0d", p, b), {rd_bin, rd_mag, rd_hit}, 41'd0);
    end
  endtask

  // Called at a negedge; that cycle is cycle 0. Returns at the negedge of the frame_done cycle.
  task automatic run_scan(input logic [31:0] ts, input logic [31:0] thr, input int extra,
                          input bit toggle, input bit mid_chk, input logic [31:0] mid_time,
                          output int done_cyc, output int edges);
    logic fv_old;
    done_cyc = -1; edges = 0; first_busy = -1; last_busy = -1;
    time_stamp = ts; threshold = thr; frame_valid = 1'b1;
    for (int cyc = 1; cyc < 600; cyc++) begin
      @(negedge clk);
      fv_old = frame_valid;
      if (cyc == 3) frame_valid = 1'b0;
      if (extra > 0 && cyc == extra) frame_valid = 1'b1;
      if (extra > 0 && cyc == extra + 2) frame_valid = 1'b0;
      if (toggle && cyc >= 4) frame_valid = (cyc <= 250) && ((cyc % 4) >= 2);
      if (!fv_old && frame_valid) edges++;
      if (scan_busy) begin
        if (first_busy < 0) first_busy = cyc;
        last_busy = cyc;
      end
      if (mid_chk && cyc == 150) check_results("hold", mid_time);
      if (frame_done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk("done_found", (done_cyc > 0), 1'b1);
  endtask

  task automatic do_frame(input string p, input logic [31:0] ts, input logic [31:0] thr,
                          input int extra, input bit toggle);
    int dc, ed;
    build_model(thr);
    run_scan(ts, thr, extra, toggle, 1'b0, 32'd0, dc, ed);
    exp_drop = (exp_drop + ed > 255) ? 255 : exp_drop + ed;
    chk({p, "_done_cyc"}, dc, 259);
    chk({p, "_busy_first"}, first_busy, 1);
    chk({p, "_busy_last"}, last_busy, 258);
    check_results(p, ts);
    chk({p, "_dropped"}, dropped_frames, exp_drop[7:0]);
    @(negedge clk);
    chk({p, "_done_pulse"}, frame_done, 1'b0);
  endtask

  initial begin
    int dc, ed, done_seen;
    reset = 1'b1; frame_valid = 1'b1; time_stamp = 32'd0; threshold = 32'd0; rd_band = 3'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (4) @(negedge clk);
    chk("rst_busy", scan_busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_addr", bin_addr, 8'd0);
    chk("rst_drop", dropped_frames, 8'd0);
    check_zero("rst");
    // frame_valid held high through reset release must not start a scan
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_high_busy", scan_busy, 1'b0);
    frame_valid = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 256; i++) mem[i] = i;
    do_frame("ramp", 32'h11, 32'd0, 0, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 32'd5;
    do_frame("flat", 32'h22, 32'd5, 0, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[100] = 32'hFFFF_FFFF;
    do_frame("spike", 32'h33, 32'd0, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      do_frame($sformatf("rand%0d", r), $urandom, $urandom, 0, 1'b0);
    end
    for (int i = 0; i < 256; i++) mem[i] = $urandom_range(0, 3);
    do_frame("ties", 32'h44, 32'd2, 0, 1'b0);

    // Overrun: one extra edge at cycle 50, then many edges to saturate
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_frame("overrun", 32'h55, 32'h8000_0000, 50, 1'b0);
    chk("overrun_one", dropped_frames, 8'd1);
    for (int r = 0; r < 5; r++) do_frame($sformatf("sat%0d", r), 32'h60 + r, $urandom, 0, 1'b1);
    chk("drop_sat", dropped_frames, 8'd255);

    // Back-to-back: second edge in the frame_done cycle
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    build_model(32'h7000_0000);
    run_scan(32'hA1, 32'h7000_0000, 0, 1'b0, 1'b0, 32'd0, dc, ed);
    chk("b2b_first_cyc", dc, 259);
    check_results("b2b_a", 32'hA1);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    run_scan(32'hB2, 32'h1000_0000, 0, 1'b0, 1'b1, 32'hA1, dc, ed);
    chk("b2b_second_cyc", dc, 259);
    build_model(32'h1000_0000);
    check_results("b2b_b", 32'hB2);
    @(negedge clk);

    // Reset mid-scan: abort, clear committed bank, no frame_done
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    time_stamp = 32'hC3; threshold = 32'd0; frame_valid = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 3) frame_valid = 1'b0;
    end
    chk("pre_abort_busy", scan_busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", scan_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_drop = 0;
    done_seen = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (frame_done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_drop", dropped_frames, 8'd0);
    check_zero("abort");
    do_frame("post_rst", 32'hD4, 32'h4000_0000, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
